counter_datachk: RTL
====================

COUNTER_DATACHK -- requirements
Module: counter_datachk

Interface
REQ-001 Parameter LOCK_CNT, default 16: consecutive matching words needed to declare lock.
REQ-002 Parameter LOSS_CNT, default 4: consecutive mismatching words in LOCKED that force loss of lock.
REQ-003 Parameter SLIP_WAIT, default 8: clk cycles to ignore data after a bitslip pulse.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 Port: clk  input  1  sole clock; all logic on rising edge.
REQ-006 Port: reset  input  1  asynchronous, active-high reset.
REQ-007 Port: data_in  input  8  deserialized word from the HPIO receive path.
REQ-008 Port: data_valid  input  1  data_in is sampled only when high.
REQ-009 Port: clear_cnt  input  1  synchronous clear of err_cnt and word_cnt.
REQ-010 Port: locked  output  1  incrementing-count pattern acquired.
REQ-011 Port: bitslip  output  1  one-cycle pulse requesting a deserializer word shift.
REQ-012 Port: err_cnt  output  16  mismatching words while LOCKED; saturates at 0xFFFF.
REQ-013 Port: word_cnt  output  32  words checked while LOCKED; wraps modulo 2^32.

Function
REQ-014 The block SHALL check that successive valid words form the sequence x, x+1, ... modulo 256 (0xFF followed by 0x00 is a match).
REQ-015 The FSM SHALL have states SEARCH, SLIP, LOCKED; reset state is SEARCH.
REQ-016 SEARCH: each valid word SHALL be compared with the previous valid word +1; a match increments match_cnt; a mismatch clears match_cnt; the predictor always reseeds from data_in.
REQ-017 SEARCH -> LOCKED SHALL occur when match_cnt reaches LOCK_CNT, and locked SHALL go high on the following edge.
REQ-018 The first valid word after entering SEARCH only seeds the predictor and is neither a match nor a mismatch.
REQ-019 LOCKED: the predictor SHALL free-run (expected <= expected+1 per valid word) and SHALL NOT reseed from data_in, so one corrupted word counts as exactly one error.
REQ-020 LOCKED: each valid word SHALL increment word_cnt; each mismatch SHALL increment err_cnt and the consecutive-miss counter; a match SHALL clear the consecutive-miss counter.
REQ-021 LOCKED -> SEARCH SHALL occur on the LOSS_CNT-th consecutive mismatch; locked SHALL deassert on the same edge; match_cnt SHALL clear.
REQ-022 err_cnt and word_cnt SHALL update on the clk edge that samples the word, i.e. visible one cycle after data_valid.
REQ-023 clear_cnt SHALL take priority over a simultaneous increment (the result is 0); it SHALL NOT affect the FSM state or locked.
REQ-024 Cycles with data_valid low SHALL change no counter, predictor or state, except the SLIP wait counter.

Reset
REQ-025 Assertion of reset SHALL immediately set state = SEARCH, locked = 0, bitslip = 0, err_cnt = 0, word_cnt = 0, and all internal counters and the predictor to 0.
REQ-026 Reset asserted mid-lock SHALL discard lock; after release, full reacquisition (LOCK_CNT matches) is required.

Configuration
REQ-027 Macro DATACHK_BITSLIP_EN defined: a mismatch in SEARCH SHALL pulse bitslip high for exactly one cycle and enter SLIP, ignore data for SLIP_WAIT cycles, then return to SEARCH with the predictor unseeded.
REQ-028 Macro DATACHK_BITSLIP_EN undefined: bitslip SHALL be tied to 0, the SLIP state SHALL be absent, and a SEARCH mismatch only reseeds the predictor.

Structure
REQ-029 A package counter_datachk_pkg SHALL hold the state enumeration and the constants DATA_W=8, ERR_W=16, WCNT_W=32.
REQ-030 The saturating err_cnt SHALL be implemented as a sub-module sat_counter (width parameter, inc, clr, saturate at all-ones); all other logic SHALL be inline.

Verification
REQ-031 Stream 0x00..0x1F, valid every cycle, macro off -> locked rises one cycle after word 0x10 is sampled; err_cnt = 0.
REQ-032 While locked, stream ...0xFE,0xFF,0x00,0x01 -> no error; word_cnt increments by 4.
REQ-033 While locked, replace one word 0x40 with 0x55 -> err_cnt = 1, locked stays high, the next word 0x41 matches.
REQ-034 While locked, send 4 consecutive corrupted words -> err_cnt = 4; locked falls on the 4th; 16 further matches relock.
REQ-035 Macro on, feed the pattern rotated by 1 bit -> bitslip pulses once per mismatch, spaced at least SLIP_WAIT+2 cycles; after the source model shifts correctly, lock is reached.
REQ-036 err_cnt preset to 0xFFFE, then 3 errors -> 0xFFFF holds; clear_cnt coincident with an error -> err_cnt = 0; reset pulse mid-lock -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/counter_datachk_pkg.sv
// Shared types and widths for the incrementing-pattern data checker.
// The SLIP state exists only when DATACHK_BITSLIP_EN is defined.
package counter_datachk_pkg;

  localparam int DATA_W = 8;
  localparam int ERR_W  = 16;
  localparam int WCNT_W = 32;

`ifdef DATACHK_BITSLIP_EN
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    LOCKED = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/counter_datachk_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/counter_datachk.sv
// Incrementing-count pattern checker with lock detection and error counting.
// Optional deserializer bitslip requests under DATACHK_BITSLIP_EN.
module counter_datachk
  import counter_datachk_pkg::*;
#(
  parameter int LOCK_CNT  = 16,
  parameter int LOSS_CNT  = 4,
  parameter int SLIP_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              clear_cnt,
  output logic              locked,
  output logic              bitslip,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WCNT_W-1:0] word_cnt
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam logic [MW-1:0] LOCK_M = MW'(LOCK_CNT);
  localparam logic [LW-1:0] LOSS_M = LW'(LOSS_CNT);

  state_t            state, state_n;
  logic [DATA_W-1:0] expected, exp_n;
  logic              seeded, seeded_n;
  logic [MW-1:0]     match_cnt, match_n;
  logic [LW-1:0]     miss_cnt, miss_n;
  logic              locked_n;
  logic              bitslip_n;
  logic              err_inc;
  logic              word_inc;
  logic              hit;

`ifdef DATACHK_BITSLIP_EN
  localparam int SW = $clog2(SLIP_WAIT + 1);
  localparam logic [SW-1:0] SLIP_LAST = SW'(SLIP_WAIT - 1);
  logic [SW-1:0] slip_cnt, slip_n;
`endif

  assign hit = (data_in == expected);

  always_comb begin
    state_n   = state;
    exp_n     = expected;
    seeded_n  = seeded;
    match_n   = match_cnt;
    miss_n    = miss_cnt;
    locked_n  = locked;
    bitslip_n = 1'b0;
    err_inc   = 1'b0;
    word_inc  = 1'b0;
`ifdef DATACHK_BITSLIP_EN
    slip_n    = slip_cnt;
`endif
    unique case (state)
      SEARCH: begin
        if (data_valid) begin
          exp_n    = data_in + 1'b1;
          seeded_n = 1'b1;
          if (seeded && hit) begin
            match_n = match_cnt + 1'b1;
            if (match_n == LOCK_M) state_n = LOCKED;
          end else if (seeded) begin
            match_n = '0;
`ifdef DATACHK_BITSLIP_EN
            bitslip_n = 1'b1;
            seeded_n  = 1'b0;
            slip_n    = '0;
            state_n   = SLIP;
`endif
          end
        end
      end
`ifdef DATACHK_BITSLIP_EN
      SLIP: begin
        // Wait counts every clock, valid or not, so the
        // deserializer gets a fixed settling window.
        slip_n = slip_cnt + 1'b1;
        if (slip_cnt == SLIP_LAST) begin
          state_n  = SEARCH;
          seeded_n = 1'b0;
        end
      end
`endif
      LOCKED: begin
        locked_n = 1'b1;
        if (data_valid) begin
          exp_n    = expected + 1'b1;
          word_inc = 1'b1;
          if (hit) begin
            miss_n = '0;
          end else begin
            err_inc = 1'b1;
            miss_n  = miss_cnt + 1'b1;
            if (miss_n == LOSS_M) begin
              state_n  = SEARCH;
              locked_n = 1'b0;
              match_n  = '0;
              miss_n   = '0;
              seeded_n = 1'b0;
            end
          end
        end
      end
      default: begin
        state_n  = SEARCH;
        locked_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      expected  <= '0;
      seeded    <= 1'b0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      bitslip   <= 1'b0;
    end else begin
      state     <= state_n;
      expected  <= exp_n;
      seeded    <= seeded_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      locked    <= locked_n;
      bitslip   <= bitslip_n;
    end
  end

`ifdef DATACHK_BITSLIP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) slip_cnt <= '0;
    else       slip_cnt <= slip_n;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt <= '0;
    end else if (clear_cnt) begin
      word_cnt <= '0;
    end else if (word_inc) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err (
    .clk(clk),
    .rst(reset),
    .inc(err_inc),
    .clr(clear_cnt),
    .cnt(err_cnt)
  );

endmodule
